inst_rom_pipe: RTL and testbench

Pipelined instruction-memory responder for the fetch stage. Each cycle it accepts at most one fetch request (`ce`, `pc`) from the PC register. It returns the addressed 32-bit instruction a fixed `LATENCY` cycles later, tagged with its address and an error flag. It never stalls the requester, so a back-to-back stream of `pc`, `pc+4`, … is sustained at one instruction per cycle. A word-wide loader port fills the array before or during execution, and a retired-fetch counter is provided for debug.

---
 rtl/inst_rom_pipe_if.sv | 27 ++
 rtl/inst_rom_pipe.sv | 81 ++++++++
 tb/tb_inst_rom_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_pipe_if.sv
// Fetch-side bus of the instruction memory: request, loader and response signals.
interface inst_rom_pipe_if #(
   parameter int unsigned DEPTH_LOG2 = 10
);
   logic                  ce;
   logic [31:0]           pc;
   logic                  ld_en;
   logic [DEPTH_LOG2-1:0] ld_addr;
   logic [31:0]           ld_data;
   logic [31:0]           inst;
   logic [31:0]           inst_pc;
   logic                  inst_valid;
   logic                  inst_err;
   logic [31:0]           fetch_cnt;

   // Requester / loader side
   modport master (
      output ce, pc, ld_en, ld_addr, ld_data,
      input  inst, inst_pc, inst_valid, inst_err, fetch_cnt
   );

   // Memory side
   modport slave (
      input  ce, pc, ld_en, ld_addr, ld_data,
      output inst, inst_pc, inst_valid, inst_err, fetch_cnt
   );
endinterface

// File: rtl/inst_rom_pipe.sv
// Pipelined instruction memory for the fetch stage: one request per cycle,
// response LATENCY cycles later, read-first loader port, retired-fetch counter.
module inst_rom_pipe #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic            clk,
   input  logic            rst,
   inst_rom_pipe_if.slave  bus
);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("inst_rom_pipe: LATENCY must be in 1..4");
   end

   if ($bits(bus.ld_addr) != DEPTH_LOG2) begin : g_bad_width
      $error("inst_rom_pipe: interface DEPTH_LOG2 differs from module DEPTH_LOG2");
   end

   logic [31:0]           mem [2**DEPTH_LOG2];

   // Stage 0 is the array-read stage; the last entry drives the outputs.
   logic                  st_valid [LATENCY];
   logic                  st_err   [LATENCY];
   logic [31:0]           st_pc    [LATENCY];
   logic [31:0]           st_data  [LATENCY];
   logic [31:0]           fetch_cnt_q;

   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  req_err;

   assign rd_idx  = bus.pc[DEPTH_LOG2+1:2];
   assign req_err = (bus.pc[1:0] != 2'b00) || (bus.pc[31:DEPTH_LOG2+2] != '0);

   // Loader write; the array is never reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (!rst && bus.ld_en) begin
         mem[bus.ld_addr] <= bus.ld_data;
      end
   end

   // Request capture, read-first array access and delay stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < LATENCY; s++) begin
            st_valid[s] <= 1'b0;
            st_err[s]   <= 1'b0;
            st_pc[s]    <= '0;
            st_data[s]  <= '0;
         end
      end else begin
         st_valid[0] <= bus.ce;
         st_err[0]   <= bus.ce && req_err;
         st_pc[0]    <= bus.ce ? bus.pc : '0;
         // Bubbles and errored requests carry zero data and skip the array.
         st_data[0]  <= (bus.ce && !req_err) ? mem[rd_idx] : '0;
         for (int unsigned s = 1; s < LATENCY; s++) begin
            st_valid[s] <= st_valid[s-1];
            st_err[s]   <= st_err[s-1];
            st_pc[s]    <= st_pc[s-1];
            st_data[s]  <= st_data[s-1];
         end
      end
   end

   // Count every response presented by the final stage, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
      end else if (st_valid[LATENCY-1]) begin
         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

   assign bus.inst       = st_data[LATENCY-1];
   assign bus.inst_pc    = st_pc[LATENCY-1];
   assign bus.inst_valid = st_valid[LATENCY-1];
   assign bus.inst_err   = st_err[LATENCY-1];
   assign bus.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_rom_pipe.sv
// Bench for inst_rom_pipe: four instances (LATENCY 1..4) share one stimulus
// stream; a scoreboard predicts every output cycle of every instance.
module tb_inst_rom_pipe;

   localparam int unsigned NL = 4;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] pc;
      logic [31:0] data;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        t_ce      = 1'b0;
   logic [31:0] t_pc      = '0;
   logic        t_ld_en   = 1'b0;
   logic [9:0]  t_ld_addr = '0;
   logic [31:0] t_ld_data = '0;

   logic [NL-1:0]       o_valid;
   logic [NL-1:0]       o_err;
   logic [NL-1:0][31:0] o_inst;
   logic [NL-1:0][31:0] o_pc;
   logic [NL-1:0][31:0] o_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_lane
      inst_rom_pipe_if #(.DEPTH_LOG2(10)) bus ();
      assign bus.ce      = t_ce;
      assign bus.pc      = t_pc;
      assign bus.ld_en   = t_ld_en;
      assign bus.ld_addr = t_ld_addr;
      assign bus.ld_data = t_ld_data;
      assign o_valid[g]  = bus.inst_valid;
      assign o_err[g]    = bus.inst_err;
      assign o_inst[g]   = bus.inst;
      assign o_pc[g]     = bus.inst_pc;
      assign o_cnt[g]    = bus.fetch_cnt;
      inst_rom_pipe #(.DEPTH_LOG2(10), .LATENCY(g + 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   // ---------------- scoreboard ----------------
   resp_t       sbq   [NL][$];
   logic [31:0] mem_m [1024];
   logic [31:0] cnt_m [NL];
   logic        last_v[NL];

   initial begin
      resp_t e;
      resp_t x;
      logic  was_rst;
      forever begin
         @(posedge clk);
         was_rst = rst;
         e = '0;
         if (!rst) begin
            if (t_ce) begin
               e.valid = 1'b1;
               e.pc    = t_pc;
               e.err   = (t_pc[1:0] != 2'b00) || (t_pc[31:12] != 20'd0);
               e.data  = e.err ? 32'h0 : mem_m[t_pc[11:2]];
            end
            if (t_ld_en) mem_m[t_ld_addr] = t_ld_data;
         end
         #1;
         for (int unsigned i = 0; i < NL; i++) begin
            if (was_rst) begin
               sbq[i].delete();
               for (int unsigned k = 0; k <= i; k++) sbq[i].push_back('0);
               cnt_m[i]  = '0;
               last_v[i] = 1'b0;
            end else begin
               sbq[i].push_back(e);
               if (last_v[i]) cnt_m[i] = cnt_m[i] + 32'd1;
            end
            x = sbq[i].pop_front();
            last_v[i] = x.valid;
            checks++;
            if ({o_valid[i], o_err[i], o_pc[i], o_inst[i], o_cnt[i]} !==
                {x.valid, x.err, x.pc, x.data, cnt_m[i]}) begin
               errors++;
               $display("FAIL lat%0d_resp t=%0t: got v=%b e=%b pc=%h inst=%h cnt=%h, want v=%b e=%b pc=%h inst=%h cnt=%h",
                        i + 1, $time, o_valid[i], o_err[i], o_pc[i], o_inst[i], o_cnt[i],
                        x.valid, x.err, x.pc, x.data, cnt_m[i]);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic c, input logic [31:0] p, input logic le,
                        input logic [9:0] la, input logic [31:0] ld, input logic r);
      @(negedge clk);
      t_ce = c; t_pc = p; t_ld_en = le; t_ld_addr = la; t_ld_data = ld; rst = r;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) drive(1'b0, 32'h0, 1'b0, 10'd0, 32'h0, 1'b0);
   endtask

   task automatic test_reset();
      for (int unsigned k = 0; k < 3; k++) drive(1'b1, 32'h0, 1'b1, 10'd0, 32'hDEAD_BEEF, 1'b1);
      @(posedge clk); #2;
      for (int unsigned i = 0; i < NL; i++) begin
         checks++;
         if ({o_valid[i], o_err[i], o_pc[i], o_inst[i], o_cnt[i]} !== '0) begin
            errors++;
            $display("FAIL reset_zero lat%0d: got v=%b e=%b pc=%h inst=%h cnt=%h, want all 0",
                     i + 1, o_valid[i], o_err[i], o_pc[i], o_inst[i], o_cnt[i]);
         end
      end
   endtask

   task automatic test_preload();
      drive(1'b0, 32'h0, 1'b1, 10'd0, 32'h1111_1111, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 10'd1, 32'h2222_2222, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 10'd2, 32'h3333_3333, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 10'd3, 32'h4444_4444, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 10'd5, 32'hAAAA_0000, 1'b0);
      idle(1);
   endtask

   task automatic test_sequential();
      logic [31:0] base [NL];
      for (int unsigned i = 0; i < NL; i++) base[i] = o_cnt[i];
      for (int unsigned k = 0; k < 4; k++) drive(1'b1, 32'(k * 4), 1'b0, 10'd0, 32'h0, 1'b0);
      idle(6);
      for (int unsigned i = 0; i < NL; i++) begin
         checks++;
         if (o_cnt[i] !== base[i] + 32'd4) begin
            errors++;
            $display("FAIL seq_cnt lat%0d: got %0d want %0d", i + 1, o_cnt[i], base[i] + 32'd4);
         end
      end
   endtask

   task automatic test_bubbles();
      drive(1'b1, 32'h0, 1'b0, 10'd0, 32'h0, 1'b0);
      drive(1'b0, $urandom, 1'b0, 10'd0, 32'h0, 1'b0);
      drive(1'b1, 32'h8, 1'b0, 10'd0, 32'h0, 1'b0);
      idle(6);
   endtask

   task automatic test_errors();
      logic [31:0] base [NL];
      for (int unsigned i = 0; i < NL; i++) base[i] = o_cnt[i];
      drive(1'b1, 32'h2, 1'b0, 10'd0, 32'h0, 1'b0);
      drive(1'b1, 32'h1000, 1'b0, 10'd0, 32'h0, 1'b0);
      idle(6);
      for (int unsigned i = 0; i < NL; i++) begin
         checks++;
         if (o_cnt[i] !== base[i] + 32'd2) begin
            errors++;
            $display("FAIL err_cnt lat%0d: got %0d want %0d", i + 1, o_cnt[i], base[i] + 32'd2);
         end
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 32'd20, 1'b1, 10'd5, 32'hBBBB_0000, 1'b0);
      drive(1'b1, 32'd20, 1'b0, 10'd0, 32'h0, 1'b0);
      idle(6);
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 32'h0, 1'b0, 10'd0, 32'h0, 1'b0);
      drive(1'b1, 32'h4, 1'b0, 10'd0, 32'h0, 1'b0);
      drive(1'b1, 32'h8, 1'b0, 10'd0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 10'd0, 32'h5555_5555, 1'b1);
      drive(1'b1, 32'hC, 1'b0, 10'd0, 32'h0, 1'b1);
      @(posedge clk); #2;
      for (int unsigned i = 0; i < NL; i++) begin
         checks++;
         if ({o_valid[i], o_err[i], o_pc[i], o_inst[i], o_cnt[i]} !== '0) begin
            errors++;
            $display("FAIL midreset_zero lat%0d: got v=%b pc=%h inst=%h cnt=%h, want all 0",
                     i + 1, o_valid[i], o_pc[i], o_inst[i], o_cnt[i]);
         end
      end
      idle(5);
      for (int unsigned k = 0; k < 4; k++) drive(1'b1, 32'(k * 4), 1'b0, 10'd0, 32'h0, 1'b0);
      idle(6);
   endtask

   task automatic test_latency();
      int first [NL];
      for (int unsigned i = 0; i < NL; i++) first[i] = -1;
      drive(1'b1, 32'hC, 1'b0, 10'd0, 32'h0, 1'b0);
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(posedge clk); #2;
         for (int unsigned i = 0; i < NL; i++)
            if (o_valid[i] === 1'b1 && first[i] < 0) first[i] = cyc;
         drive(1'b0, 32'h0, 1'b0, 10'd0, 32'h0, 1'b0);
      end
      for (int unsigned i = 0; i < NL; i++) begin
         checks++;
         if (first[i] != int'(i + 1)) begin
            errors++;
            $display("FAIL latency lat%0d: got offset %0d want %0d", i + 1, first[i], i + 1);
         end
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force g_lane[0].u_dut.fetch_cnt_q = 32'hFFFF_FFFF;
      force g_lane[1].u_dut.fetch_cnt_q = 32'hFFFF_FFFF;
      force g_lane[2].u_dut.fetch_cnt_q = 32'hFFFF_FFFF;
      force g_lane[3].u_dut.fetch_cnt_q = 32'hFFFF_FFFF;
      for (int unsigned i = 0; i < NL; i++) cnt_m[i] = 32'hFFFF_FFFF;
      #1;
      release g_lane[0].u_dut.fetch_cnt_q;
      release g_lane[1].u_dut.fetch_cnt_q;
      release g_lane[2].u_dut.fetch_cnt_q;
      release g_lane[3].u_dut.fetch_cnt_q;
      drive(1'b1, 32'h4, 1'b0, 10'd0, 32'h0, 1'b0);
      idle(6);
      for (int unsigned i = 0; i < NL; i++) begin
         checks++;
         if (o_cnt[i] !== 32'h0) begin
            errors++;
            $display("FAIL cnt_wrap lat%0d: got %h want 00000000", i + 1, o_cnt[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_preload();
      test_sequential();
      test_bubbles();
      test_errors();
      test_collision();
      test_reset_midstream();
      test_latency();
      test_wrap();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
